alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 32-bit ALU between two requesters in the pipelined datapath. Round-robin arbitration with valid/ready handshakes on the request side and a single tagged response channel. The block drives the ALU's operand and select inputs from internal registers and captures the ALU result and carry into a registered response.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU instance.
- SELECT_WIDTH, 3, opcode width; must match the ALU instance.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  requester n's operation is accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands.
- req0_op / req1_op  in  SELECT_WIDTH  ALU select code.
- rsp_valid  out  1  response is held.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester index of the response.
- rsp_data  out  DATA_WIDTH  captured ALU result.
- rsp_carry  out  1  captured ALU carry_out.
- rsp_err  out  1  illegal opcode flag (see Configuration).
- alu_in1, alu_in2  out  DATA_WIDTH  to the ALU operand inputs.
- alu_select  out  SELECT_WIDTH  to the ALU select input.
- alu_out  in  DATA_WIDTH  from the ALU result.
- alu_carry_out  in  1  from the ALU carry.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If either reqN_valid is high, grant one requester.
  - Assert its reqN_ready combinationally in the same cycle.
  - On the clock edge, capture a/b/op into the operand registers and the grant into id_q, then go to EXEC.
  - With no valid request, stay in IDLE.
- **Arbitration**
  - One valid requester wins.
  - Both valid: the requester not equal to last_grant wins, and last_grant updates on grant.
  - A ready signal is never high outside IDLE, and never high for the losing requester.
- **EXEC**
  - Operand registers drive the ALU.
  - On the edge, capture alu_out into rsp_data and alu_carry_out into rsp_carry, then go to RESP.
- **RESP**
  - rsp_valid=1; rsp_id, rsp_data, rsp_carry and rsp_err are held stable.
  - When rsp_ready=1, go to IDLE on the edge.
  - With rsp_ready low, stay in RESP indefinitely; requests are stalled (ready low).
- **ALU drive**
  - alu_in1, alu_in2 and alu_select always equal the operand registers.
  - They change only on an IDLE accept edge.
- **Width rules**
  - No width conversion.
  - rsp_carry is the ALU's unsigned in1+in2 carry for every opcode, passed through unmodified.
- **Reset** (rst=1 at an edge, any state):
  - FSM goes to IDLE; last_grant=1, so requester 0 wins the first contention.
  - Operand registers, rsp_data, rsp_carry, rsp_err and id_q are cleared to 0.
  - Any in-flight operation is discarded with no response.
  - Output reset values: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_carry=0, rsp_err=0, req0_ready=0, req1_ready=0, alu_in1=0, alu_in2=0, alu_select=0.
  - Ready signals stay 0 while rst is high.

## Timing
- Request accepted at edge T (valid & ready high in cycle T-1 → captured at T).
- EXEC occupies cycle T; rsp_valid rises after edge T+1.
- Minimum accept-to-response latency: 2 cycles.
- Minimum issue interval: 3 cycles (accept, exec, resp with rsp_ready=1).
- A new accept can occur in the cycle immediately after the RESP handshake edge.
- The ALU path is one full cycle: combinational from operand registers to the rsp_data register.

## Configuration
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - Captured op 3'b010, which has no ALU function, is illegal.
  - The FSM goes IDLE→RESP directly, skipping EXEC.
  - Response: rsp_data=0, rsp_carry=0, rsp_err=1; latency is 1 cycle.
  - All legal ops give rsp_err=0.
- Undefined:
  - No check; 3'b010 passes through EXEC like any op.
  - rsp_data is whatever the ALU presents; rsp_err is tied 0.

## Test plan
- Reset then single op: req0 a=5, b=3, op=3'b101 → req0_ready high in the request cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=8, rsp_carry=0.
- Contention: both valid every cycle from reset, req0 op=3'b110 (10-4), req1 op=3'b100 (0xF0&0x3C), rsp_ready=1.
  - Grants alternate 0,1,0,1.
  - Responses: id0 data=6; id1 data=0x30.
- Carry and backpressure: req1 a=0xFFFFFFFF, b=1, op=3'b101, rsp_ready held 0 for 5 cycles.
  - Response holds data=0, carry=1, id=1 stable.
  - req0_ready and req1_ready stay 0 until the handshake.
- Reset mid-op: rst pulsed in the EXEC cycle → no rsp_valid afterwards and all outputs 0; the next request is handled normally.
- Illegal op 3'b010 on req0:
  - With ALU_ARB_OPCHECK_EN: rsp_valid 1 cycle after accept, rsp_err=1, data=0.
  - Without it: 2-cycle latency, rsp_err=0.
- SLT op: req0 a=2, b=9, op=3'b111 → rsp_data=1; a=9, b=2 → rsp_data=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Optional illegal-opcode check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [DATA_WIDTH-1:0]   req0_a,
    input  logic [DATA_WIDTH-1:0]   req0_b,
    input  logic [SELECT_WIDTH-1:0] req0_op,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [DATA_WIDTH-1:0]   req1_a,
    input  logic [DATA_WIDTH-1:0]   req1_b,
    input  logic [SELECT_WIDTH-1:0] req1_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_carry,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   alu_in1,
    output logic [DATA_WIDTH-1:0]   alu_in2,
    output logic [SELECT_WIDTH-1:0] alu_select,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic                    alu_carry_out
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

`ifdef ALU_ARB_OPCHECK_EN
    localparam logic [SELECT_WIDTH-1:0] OpIllegal = SELECT_WIDTH'(2);
    logic err_q, err_d;
`endif

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, data_q, data_d;
    logic [SELECT_WIDTH-1:0] op_q, op_d;
    logic                    id_q, id_d, last_q, last_d, carry_q, carry_d;

    logic                    accept, grant;
    logic [DATA_WIDTH-1:0]   sel_a, sel_b;
    logic [SELECT_WIDTH-1:0] sel_op;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        grant  = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        accept = (state_q == StIdle) & (req0_valid | req1_valid) & ~rst;
        sel_a  = grant ? req1_a : req0_a;
        sel_b  = grant ? req1_b : req0_b;
        sel_op = grant ? req1_op : req0_op;
    end

    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        data_d  = data_q;
        carry_d = carry_q;
`ifdef ALU_ARB_OPCHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    id_d    = grant;
                    last_d  = grant;
                    state_d = StExec;
`ifdef ALU_ARB_OPCHECK_EN
                    // Illegal opcode bypasses the ALU and answers one cycle earlier.
                    if (sel_op == OpIllegal) begin
                        data_d  = '0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
`endif
                end
            end
            StExec: begin
                data_d  = alu_out;
                carry_d = alu_carry_out;
`ifdef ALU_ARB_OPCHECK_EN
                err_d   = 1'b0;
`endif
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
            carry_q <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            data_q  <= data_d;
            carry_q <= carry_d;
`ifdef ALU_ARB_OPCHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_carry  = carry_q;
`ifdef ALU_ARB_OPCHECK_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif
    assign alu_in1    = a_q;
    assign alu_in2    = b_q;
    assign alu_select = op_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_carry, rsp_err;
    logic [31:0] rsp_data, alu_in1, alu_in2, alu_out;
    logic [2:0]  alu_select;
    logic        alu_carry_out;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(32), .SELECT_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_select(alu_select),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out)
    );

    // Behavioural ALU; op 2 has no defined function and yields a junk pattern.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return a | b;
            3'd1:    return a ^ b;
            3'd2:    return ~(a ^ b);
            3'd3:    return a << b[4:0];
            3'd4:    return a & b;
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic carry_f(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32];
    endfunction

    always_comb begin
        alu_out       = alu_f(alu_in1, alu_in2, alu_select);
        alu_carry_out = carry_f(alu_in1, alu_in2);
    end

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        carry;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every held response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d data=%0h expected no response",
                         rsp_id, rsp_data);
            end else begin
                chk("rsp", {rsp_id, rsp_data, rsp_carry, rsp_err}, sb[0]);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    // Requester-side pending operations, held until accepted.
    logic        p0 = 0, p1 = 0;
    logic [31:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;

    // Reference model: busy flag, edges left until the response shows, last winner.
    logic        m_busy = 0, m_last = 1, m_rst_prev = 0;
    int          m_cnt = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [2:0]  m_op = '0;

    task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        p0 = 1; a0 = a; b0 = b; op0 = op;
    endtask

    task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        p1 = 1; a1 = a; b1 = b; op1 = op;
    endtask

    task automatic step(input logic rr, input logic r);
        logic        w, e0, e1, ill;
        logic [31:0] ta, tb;
        logic [2:0]  top;
        rsp_t        e;
        @(posedge clk);
        #1;
        rst = r; rsp_ready = rr;
        req0_valid = p0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = p1; req1_a = a1; req1_b = b1; req1_op = op1;
        @(negedge clk);
        w = 0; e0 = 0; e1 = 0;
        if (!r && !m_busy && (p0 || p1)) begin
            w  = (p0 && p1) ? ~m_last : p1;
            e0 = ~w;
            e1 = w;
        end
        chk("req_ready", {req0_ready, req1_ready}, {e0, e1});
        if (!r) chk("rsp_valid", rsp_valid, m_busy && m_cnt == 0);
        chk("alu_drive", {alu_in1, alu_in2, alu_select}, {m_a, m_b, m_op});
        if (m_rst_prev)
            chk("post_reset", {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err}, '0);
        if (r) begin
            m_busy = 0; m_cnt = 0; m_last = 1;
            m_a = '0; m_b = '0; m_op = '0;
            sb.delete();
        end else if (m_busy) begin
            if (m_cnt > 0) m_cnt--;
            else if (rr) m_busy = 0;
        end else if (e0 || e1) begin
            ta  = w ? a1 : a0;
            tb  = w ? b1 : b0;
            top = w ? op1 : op0;
`ifdef ALU_ARB_OPCHECK_EN
            ill = (top == 3'd2);
`else
            ill = 1'b0;
`endif
            if (ill) e = '{id: w, data: 32'd0, carry: 1'b0, err: 1'b1};
            else     e = '{id: w, data: alu_f(ta, tb, top), carry: carry_f(ta, tb), err: 1'b0};
            sb.push_back(e);
            m_a = ta; m_b = tb; m_op = top;
            m_last = w; m_busy = 1; m_cnt = ill ? 0 : 1;
            if (w) p1 = 0;
            else   p0 = 0;
        end
        m_rst_prev = r;
    endtask

    initial begin
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
        repeat (2) step(0, 1);

        // Single add on requester 0.
        set0(32'd5, 32'd3, 3'b101);
        repeat (4) step(1, 0);

        // Contention straight out of reset: grants must alternate starting with 0.
        step(0, 1);
        for (int i = 0; i < 12; i++) begin
            if (!p0) set0(32'd10, 32'd4, 3'b110);
            if (!p1) set1(32'hF0, 32'h3C, 3'b100);
            step(1, 0);
        end
        p0 = 0; p1 = 0;
        repeat (4) step(1, 0);

        // Carry out with backpressure; a request arriving mid-stall must wait.
        set1(32'hFFFF_FFFF, 32'd1, 3'b101);
        step(0, 0);
        step(0, 0);
        set0(32'd7, 32'd7, 3'b101);
        repeat (5) step(0, 0);
        repeat (5) step(1, 0);

        // Reset during EXEC drops the operation; the next one proceeds normally.
        set0(32'd1, 32'd2, 3'b101);
        step(1, 0);
        step(1, 1);
        repeat (2) step(1, 0);
        set0(32'd3, 32'd4, 3'b101);
        repeat (4) step(1, 0);

        // Opcode without an ALU function.
        set0(32'd6, 32'd7, 3'b010);
        repeat (4) step(1, 0);

        // Set-less-than both ways.
        set0(32'd2, 32'd9, 3'b111);
        repeat (4) step(1, 0);
        set0(32'd9, 32'd2, 3'b111);
        repeat (4) step(1, 0);

        // Random traffic, backpressure and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(2) == 0)
                set0(($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                     3'($urandom_range(7)));
            if (!p1 && $urandom_range(2) == 0)
                set1($urandom, ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom,
                     3'($urandom_range(7)));
            step(1'($urandom_range(3) != 0), 1'($urandom_range(49) == 0));
        end

        p0 = 0; p1 = 0;
        repeat (8) step(1, 0);
        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
